// File: rtl/ntt_pkg.sv
// Shared NTT-path constants: default modulus q, coefficient/product widths and
// the state encoding used by the sequential reducer.
package ntt_pkg;

  localparam int Q      = 3329;
  localparam int COEF_W = 12;
  localparam int PROD_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pick the divisor actually used for an operation.
  function automatic logic [COEF_W-1:0] eff_mod(input logic             use_default,
                                                input logic [COEF_W-1:0] modulus);
    logic [COEF_W-1:0] w_q;
    w_q = COEF_W'(Q);
    return use_default ? w_q : modulus;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift one dividend bit into the partial remainder,
// subtract the modulus if it fits, and emit the quotient bit.
module div_step #(
  parameter int MWIDTH = 12
) (
  input  logic [MWIDTH-1:0] i_r,
  input  logic              i_bit,
  input  logic [MWIDTH-1:0] i_mod,
  output logic [MWIDTH-1:0] o_r,
  output logic              o_qbit
);

  logic [MWIDTH:0] w_shift;
  logic [MWIDTH:0] w_diff;

  // The incoming remainder is always below the modulus, so the MWIDTH+1-bit shift never overflows.
  always_comb begin
    w_shift = {i_r, i_bit};
    w_diff  = w_shift - {1'b0, i_mod};
    if (w_shift >= {1'b0, i_mod}) begin
      o_r    = w_diff[MWIDTH-1:0];
      o_qbit = 1'b1;
    end else begin
      o_r    = w_shift[MWIDTH-1:0];
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_mod_reduce.sv
// Sequential restoring divider reducing a product modulo q with fixed,
// data-independent latency of DWIDTH iterations.
module seq_mod_reduce
  import ntt_pkg::*;
#(
  parameter int DWIDTH    = PROD_W,
  parameter int MWIDTH    = COEF_W,
  parameter int DEFAULT_Q = Q
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DWIDTH-1:0] dividend_i,
  input  logic [MWIDTH-1:0] modulus_i,
  input  logic              use_default_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DWIDTH-1:0] quot_o,
  output logic [MWIDTH-1:0] rem_o,
  output logic              div_zero_o
);

  localparam int CNT_W = $clog2(DWIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [MWIDTH-1:0] MOD_DEF = MWIDTH'(DEFAULT_Q);

  state_e            r_state;
  logic [DWIDTH-1:0] r_dvd;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [MWIDTH-1:0] r_part;
  logic [MWIDTH-1:0] r_mod;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DWIDTH-1:0] r_quot;
  logic [MWIDTH-1:0] r_rem;
  logic              r_div_zero;

  logic [MWIDTH-1:0] w_mod_eff;
  logic [MWIDTH-1:0] w_r_next;
  logic              w_qbit;

  assign w_mod_eff = use_default_i ? MOD_DEF : modulus_i;

  div_step #(.MWIDTH(MWIDTH)) u_step (
    .i_r    (r_part),
    .i_bit  (r_dvd[DWIDTH-1]),
    .i_mod  (r_mod),
    .o_r    (w_r_next),
    .o_qbit (w_qbit)
  );

  // Control FSM, datapath registers and registered results.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_dvd      <= '0;
      r_part     <= '0;
      r_mod      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_dvd  <= dividend_i;
            r_mod  <= w_mod_eff;
            r_cnt  <= CNT_LAST;
            r_part <= '0;
            if (w_mod_eff == '0) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_quot     <= '1;
              r_rem      <= dividend_i[MWIDTH-1:0];
              r_div_zero <= 1'b1;
            end else begin
              r_state <= ST_ITER;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          r_part <= w_r_next;
          r_dvd  <= {r_dvd[DWIDTH-2:0], w_qbit};
          r_cnt  <= r_cnt - CNT_ONE;
          if (r_cnt == '0) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_quot     <= {r_dvd[DWIDTH-2:0], w_qbit};
            r_rem      <= w_r_next;
            r_div_zero <= 1'b0;
          end else begin
            r_state <= ST_ITER;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign quot_o     = r_quot;
  assign rem_o      = r_rem;
  assign div_zero_o = r_div_zero;

endmodule

// File: tb/tb_seq_mod_reduce.sv
// Directed and random self-checking bench for seq_mod_reduce.
module tb_seq_mod_reduce;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [23:0] dividend_i;
  logic [11:0] modulus_i;
  logic        use_default_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] quot_o;
  logic [11:0] rem_o;
  logic        div_zero_o;

  int unsigned cyc = 0;
  int unsigned t0  = 0;
  int          checks = 0;
  int          errors = 0;

  seq_mod_reduce dut (
    .clock_i       (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .dividend_i    (dividend_i),
    .modulus_i     (modulus_i),
    .use_default_i (use_default_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quot_o        (quot_o),
    .rem_o         (rem_o),
    .div_zero_o    (div_zero_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is high for exactly one cycle (cycle T).
  task automatic start_op(input logic [23:0] d, input logic [11:0] m, input logic use_def);
    dividend_i    = d;
    modulus_i     = m;
    use_default_i = use_def;
    start_i       = 1'b1;
    t0            = cyc;
    @(negedge clk);
    start_i       = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (!done_o && (cyc - t0) < 200) @(negedge clk);
    check({tag, "_done_seen"}, {47'd0, done_o}, 48'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {47'd0, busy_o}, 48'd0);
    check({tag, "_done"}, {47'd0, done_o}, 48'd0);
    check({tag, "_quot"}, {24'd0, quot_o}, 48'd0);
    check({tag, "_rem"},  {36'd0, rem_o},  48'd0);
    check({tag, "_dz"},   {47'd0, div_zero_o}, 48'd0);
  endtask

  initial begin
    int unsigned lat;
    int          done_cnt;
    logic [23:0] rd;
    logic [11:0] rm;
    logic        ru;
    logic [11:0] em;

    reset_i = 1'b1; start_i = 1'b0; dividend_i = 24'd0; modulus_i = 12'd0; use_default_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    check_outputs_zero("reset");

    // Default modulus: 3329*3328
    start_op(24'd11078912, 12'd0, 1'b1);
    check("t1_busy", {47'd0, busy_o}, 48'd1);
    wait_done("t1");
    check("t1_lat",  48'(cyc - t0), 48'd25);
    check("t1_quot", {24'd0, quot_o}, 48'd3328);
    check("t1_rem",  {36'd0, rem_o},  48'd0);
    check("t1_dz",   {47'd0, div_zero_o}, 48'd0);
    check("t1_busy_done", {47'd0, busy_o}, 48'd0);

    // 4095*4095 mod 3329
    start_op(24'd16769025, 12'd3329, 1'b0);
    wait_done("t2");
    check("t2_quot", {24'd0, quot_o}, 48'd5037);
    check("t2_rem",  {36'd0, rem_o},  48'd852);

    start_op(24'd3328, 12'd3329, 1'b0);
    wait_done("t3a");
    check("t3a_quot", {24'd0, quot_o}, 48'd0);
    check("t3a_rem",  {36'd0, rem_o},  48'd3328);

    start_op(24'hFFFFFF, 12'd1, 1'b0);
    wait_done("t3b");
    check("t3b_lat",  48'(cyc - t0), 48'd25);
    check("t3b_quot", {24'd0, quot_o}, 48'hFFFFFF);
    check("t3b_rem",  {36'd0, rem_o},  48'd0);

    // Zero modulus
    @(negedge clk);
    start_op(24'h000ABC, 12'd0, 1'b0);
    wait_done("t4");
    check("t4_lat",  48'(cyc - t0), 48'd1);
    check("t4_quot", {24'd0, quot_o}, 48'hFFFFFF);
    check("t4_rem",  {36'd0, rem_o},  48'hABC);
    check("t4_dz",   {47'd0, div_zero_o}, 48'd1);
    @(negedge clk);
    check("t4_hold_done", {47'd0, done_o}, 48'd0);
    check("t4_hold_quot", {24'd0, quot_o}, 48'hFFFFFF);
    check("t4_hold_dz",   {47'd0, div_zero_o}, 48'd1);
    start_op(24'd100, 12'd7, 1'b0);
    check("t4b_dz_busy", {47'd0, div_zero_o}, 48'd1);
    wait_done("t4b");
    check("t4b_quot", {24'd0, quot_o}, 48'd14);
    check("t4b_rem",  {36'd0, rem_o},  48'd2);
    check("t4b_dz",   {47'd0, div_zero_o}, 48'd0);

    // start while busy is ignored; start in DONE gives back-to-back ops
    @(negedge clk);
    start_op(24'd1000, 12'd13, 1'b0);
    repeat (3) @(negedge clk);
    dividend_i = 24'd50; modulus_i = 12'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("t5a");
    check("t5a_lat",  48'(cyc - t0), 48'd25);
    check("t5a_quot", {24'd0, quot_o}, 48'd76);
    check("t5a_rem",  {36'd0, rem_o},  48'd12);
    lat = t0;
    dividend_i = 24'd100; modulus_i = 12'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t0 = lat;
    check("t5b_busy", {47'd0, busy_o}, 48'd1);
    wait_done("t5b");
    check("t5b_lat",  48'(cyc - t0), 48'd50);
    check("t5b_quot", {24'd0, quot_o}, 48'd14);
    check("t5b_rem",  {36'd0, rem_o},  48'd2);

    // Reset in the middle of an op
    @(negedge clk);
    start_op(24'd1000, 12'd13, 1'b0);
    while ((cyc - t0) < 10) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check_outputs_zero("t6_rst");
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    check("t6_no_done", 48'(done_cnt), 48'd0);

    // Reset and start together: start dropped
    reset_i = 1'b1; start_i = 1'b1; dividend_i = 24'd100; modulus_i = 12'd7;
    @(negedge clk);
    reset_i = 1'b0; start_i = 1'b0;
    check("t6_rs_busy", {47'd0, busy_o}, 48'd0);
    repeat (30) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    check("t6_rs_no_done", 48'(done_cnt), 48'd0);

    start_op(24'd1000, 12'd13, 1'b0);
    wait_done("t6c");
    check("t6c_quot", {24'd0, quot_o}, 48'd76);
    check("t6c_rem",  {36'd0, rem_o},  48'd12);

    // Random scoreboard
    for (int i = 0; i < 1000; i++) begin
      rd = 24'($urandom);
      rm = 12'($urandom_range(4095, 1));
      ru = ($urandom_range(7, 0) == 0);
      em = ru ? 12'd3329 : rm;
      start_op(rd, rm, ru);
      wait_done("rnd");
      check("rnd_lat", 48'(cyc - t0), 48'd25);
      check("rnd_exact", 48'(quot_o) * 48'(em) + 48'(rem_o), 48'(rd));
      check("rnd_rem_lt", {47'd0, (rem_o < em)}, 48'd1);
      check("rnd_quot", 48'(quot_o), 48'(rd / em));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
